mdu_issue_ctrl: RTL and testbench

//   Sequences the pipeline's multiply/divide unit from the E stage and generates the D-stage stall for it.

---
 rtl/mdu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue control for the multiply/divide unit: shadows MDU latency,
// gates start and HI/LO write strobes, and raises the D-stage stall.
module mdu_issue_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_md_use,
    input  logic                   e_valid,
    input  logic [2:0]             e_md_kind,
    input  logic [2:0]             e_md_op,
    input  logic                   mdu_busy,
    output logic                   stall_d,
    output logic                   mdu_start,
    output logic [2:0]             mdu_op,
    output logic                   mdu_hi_write,
    output logic                   mdu_lo_write,
    output logic [1:0]             e_hilo_sel,
    output logic                   busy_o,
    output logic                   done_pulse,
    output logic                   sync_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] KIND_NONE  = 3'd0;
    localparam logic [2:0] KIND_START = 3'd1;
    localparam logic [2:0] KIND_MTHI  = 3'd2;
    localparam logic [2:0] KIND_MTLO  = 3'd3;
    localparam logic [2:0] KIND_MFHI  = 3'd4;
    localparam logic [2:0] KIND_MFLO  = 3'd5;
    localparam logic [2:0] KIND_SWAP  = 3'd6;
    localparam logic [2:0] OP_SWAP    = 3'd4;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_pulse_q, done_pulse_d;
    logic                   sync_err_q, sync_err_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic is_idle;
    logic is_run;
    logic e_issue_kind;

    assign is_idle = (state_q == IDLE);
    assign is_run  = (state_q == RUN);

    // Kinds that drive the MDU and must never overlap a running op.
    assign e_issue_kind = e_valid & ((e_md_kind == KIND_START) | (e_md_kind == KIND_MTHI) |
                                     (e_md_kind == KIND_MTLO)  | (e_md_kind == KIND_SWAP));

    always_comb begin
        mdu_start    = e_valid & (e_md_kind == KIND_START) & is_idle;
        mdu_hi_write = e_valid & (e_md_kind == KIND_MTHI) & is_idle;
        mdu_lo_write = e_valid & (e_md_kind == KIND_MTLO) & is_idle;
        mdu_op       = 3'd0;
        e_hilo_sel   = 2'd0;
        if (e_valid) begin
            if (e_md_kind == KIND_SWAP) begin
                if (is_idle) mdu_op = OP_SWAP;
            end else begin
                mdu_op = e_md_op;
            end
            if (e_md_kind == KIND_MFHI) e_hilo_sel = 2'd1;
            if (e_md_kind == KIND_MFLO) e_hilo_sel = 2'd2;
        end
        stall_d = d_md_use & (is_run | (e_valid & (e_md_kind != KIND_NONE)));
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_pulse_d   = 1'b0;
        sync_err_d     = sync_err_q;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            IDLE: begin
                if (mdu_start) begin
                    state_d = RUN;
                    cnt_d   = (e_md_op < 3'd2) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    done_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if ((mdu_busy != is_run) || (e_issue_kind && is_run)) sync_err_d = 1'b1;

        if (stall_d && (stall_cycles_q != {STALL_CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            done_pulse_q   <= 1'b0;
            sync_err_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            done_pulse_q   <= done_pulse_d;
            sync_err_q     <= sync_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign busy_o       = is_run;
    assign done_pulse   = done_pulse_q;
    assign sync_err     = sync_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed self-checking bench for mdu_issue_ctrl.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_md_use;
    logic        e_valid;
    logic [2:0]  e_md_kind;
    logic [2:0]  e_md_op;
    logic        mdu_busy;
    logic        stall_d;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic        mdu_hi_write;
    logic        mdu_lo_write;
    logic [1:0]  e_hilo_sel;
    logic        busy_o;
    logic        done_pulse;
    logic        sync_err;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .d_md_use(d_md_use), .e_valid(e_valid),
        .e_md_kind(e_md_kind), .e_md_op(e_md_op), .mdu_busy(mdu_busy),
        .stall_d(stall_d), .mdu_start(mdu_start), .mdu_op(mdu_op),
        .mdu_hi_write(mdu_hi_write), .mdu_lo_write(mdu_lo_write),
        .e_hilo_sel(e_hilo_sel), .busy_o(busy_o), .done_pulse(done_pulse),
        .sync_err(sync_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_md_use  = 1'b0;
        e_valid   = 1'b0;
        e_md_kind = 3'd0;
        e_md_op   = 3'd0;
        mdu_busy  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({stall_d, mdu_start, mdu_op, mdu_hi_write, mdu_lo_write, e_hilo_sel,
             busy_o, done_pulse, sync_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b start=%b op=%0d hw=%b lw=%b sel=%0d busy=%b done=%b err=%b, want all 0",
                     stall_d, mdu_start, mdu_op, mdu_hi_write, mdu_lo_write, e_hilo_sel,
                     busy_o, done_pulse, sync_err);
        end
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
        end
    endtask

    // Issue a start at E with an MFxx waiting in D, then track the run with a matching busy flag.
    task automatic run_op(input logic [2:0] op, input int lat, input string nm);
        int bad_busy;
        int bad_stall;
        e_valid = 1'b1; e_md_kind = 3'd1; e_md_op = op; d_md_use = 1'b1;
        #1;
        n_checks++;
        if (mdu_start !== 1'b1 || stall_d !== 1'b1 || mdu_op !== op) begin
            n_fail++;
            $display("FAIL %s_issue: got start=%b stall=%b op=%0d want 1 1 %0d", nm, mdu_start, stall_d, mdu_op, op);
        end
        tick();
        e_valid = 1'b0; e_md_kind = 3'd0; mdu_busy = 1'b1;
        bad_busy = 0; bad_stall = 0;
        for (int i = 0; i < lat; i++) begin
            #1;
            if (busy_o !== 1'b1 || done_pulse !== 1'b0 || mdu_start !== 1'b0) bad_busy++;
            if (stall_d !== 1'b1) bad_stall++;
            tick();
        end
        mdu_busy = 1'b0;
        #1;
        n_checks++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL %s_busy_window: %0d bad cycles, want 0", nm, bad_busy);
        end
        n_checks++;
        if (bad_stall != 0) begin
            n_fail++;
            $display("FAIL %s_stall_window: %0d unstalled cycles, want 0", nm, bad_stall);
        end
        n_checks++;
        if (busy_o !== 1'b0 || done_pulse !== 1'b1 || stall_d !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: got busy=%b done=%b stall=%b want 0 1 0", nm, busy_o, done_pulse, stall_d);
        end
        tick();
        d_md_use = 1'b0;
        #1;
        n_checks++;
        if (stall_cycles !== 16'(lat + 1) || sync_err !== 1'b0 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: got stall_cycles=%0d err=%b done=%b want %0d 0 0",
                     nm, stall_cycles, sync_err, done_pulse, lat + 1);
        end
    endtask

    task automatic test_mult();
        do_reset();
        run_op(3'd0, 5, "mult");
    endtask

    task automatic test_divu_zero();
        do_reset();
        run_op(3'd3, 10, "divu");
    endtask

    task automatic test_mthi();
        do_reset();
        e_valid = 1'b1; e_md_kind = 3'd2; d_md_use = 1'b1;
        #1;
        n_checks++;
        if (mdu_hi_write !== 1'b1 || mdu_lo_write !== 1'b0 || mdu_start !== 1'b0 || stall_d !== 1'b1) begin
            n_fail++;
            $display("FAIL mthi_issue: got hw=%b lw=%b start=%b stall=%b want 1 0 0 1",
                     mdu_hi_write, mdu_lo_write, mdu_start, stall_d);
        end
        tick();
        e_valid = 1'b0; e_md_kind = 3'd0;
        #1;
        n_checks++;
        if (stall_d !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_release: got stall=%b busy=%b want 0 0", stall_d, busy_o);
        end
        tick();
        d_md_use = 1'b0;
        n_checks++;
        if (stall_cycles !== 16'd1) begin
            n_fail++;
            $display("FAIL mthi_stall_cycles: got %0d want 1", stall_cycles);
        end
        e_valid = 1'b1; e_md_kind = 3'd3;
        #1;
        n_checks++;
        if (mdu_lo_write !== 1'b1 || mdu_hi_write !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo_issue: got lw=%b hw=%b want 1 0", mdu_lo_write, mdu_hi_write);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_illegal_issue();
        do_reset();
        e_valid = 1'b1; e_md_kind = 3'd1; e_md_op = 3'd1;
        tick();
        mdu_busy = 1'b1;
        #1;
        n_checks++;
        if (mdu_start !== 1'b0 || busy_o !== 1'b1 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_suppress: got start=%b busy=%b err=%b want 0 1 0", mdu_start, busy_o, sync_err);
        end
        tick();
        e_md_kind = 3'd2;
        #1;
        n_checks++;
        if (sync_err !== 1'b1 || mdu_hi_write !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_flag: got err=%b hw=%b want 1 0", sync_err, mdu_hi_write);
        end
        e_valid = 1'b0; e_md_kind = 3'd0;
        for (int i = 0; i < 3; i++) tick();
        mdu_busy = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if (sync_err !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_sticky: got err=%b busy=%b want 1 0", sync_err, busy_o);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        e_valid = 1'b1; e_md_kind = 3'd1; e_md_op = 3'd2; d_md_use = 1'b1;
        tick();
        e_valid = 1'b0; e_md_kind = 3'd0; mdu_busy = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        #1;
        n_checks++;
        if (busy_o !== 1'b1 || stall_cycles !== 16'd8) begin
            n_fail++;
            $display("FAIL midrst_pre: got busy=%b stall_cycles=%0d want 1 8", busy_o, stall_cycles);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; mdu_busy = 1'b0; d_md_use = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || done_pulse !== 1'b0 || stall_cycles !== 16'd0 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_post: got busy=%b done=%b stall_cycles=%0d err=%b want 0 0 0 0",
                     busy_o, done_pulse, stall_cycles, sync_err);
        end
        tick();
        n_checks++;
        if (done_pulse !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_nodone: got done=%b busy=%b want 0 0", done_pulse, busy_o);
        end
    endtask

    task automatic test_busy_mismatch();
        do_reset();
        e_valid = 1'b1; e_md_kind = 3'd1; e_md_op = 3'd0;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (sync_err !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mismatch: got err=%b want 1", sync_err);
        end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_swap_and_sel();
        do_reset();
        e_valid = 1'b1; e_md_kind = 3'd6; e_md_op = 3'd2;
        #1;
        n_checks++;
        if (mdu_op !== 3'd4 || mdu_start !== 1'b0 || mdu_hi_write !== 1'b0 || mdu_lo_write !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_idle: got op=%0d start=%b hw=%b lw=%b want 4 0 0 0",
                     mdu_op, mdu_start, mdu_hi_write, mdu_lo_write);
        end
        e_md_kind = 3'd4;
        #1;
        n_checks++;
        if (e_hilo_sel !== 2'd1 || mdu_op !== 3'd2) begin
            n_fail++;
            $display("FAIL sel_mfhi: got sel=%0d op=%0d want 1 2", e_hilo_sel, mdu_op);
        end
        e_md_kind = 3'd5;
        #1;
        n_checks++;
        if (e_hilo_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL sel_mflo: got sel=%0d want 2", e_hilo_sel);
        end
        e_valid = 1'b0;
        #1;
        n_checks++;
        if (e_hilo_sel !== 2'd0 || mdu_op !== 3'd0 || stall_d !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_bubble: got sel=%0d op=%0d stall=%b want 0 0 0", e_hilo_sel, mdu_op, stall_d);
        end
        tick();
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_no_err: got err=%b want 0", sync_err);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_divu_zero();
        test_mthi();
        test_illegal_issue();
        test_reset_mid_op();
        test_busy_mismatch();
        test_swap_and_sel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
